// File: rtl/decrypt_pipe_seq.sv
// Byte decryption front end: classifies and keys each accepted byte for an external
// fixed-latency shift stage, then buffers the stage results in a credit-managed output FIFO.
module decrypt_pipe_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int KEY_SLOTS  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_load_i,
   input  logic [3*KEY_SLOTS-1:0] cfg_key_i,
   input  logic [2:0]             cfg_key_len_i,
   input  logic                   cfg_mode_i,
   output logic                   cfg_busy_o,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [7:0]             in_data_i,
   output logic                   pipe_en_o,
   output logic                   pipe_shift_en_o,
   output logic                   pipe_mode_o,
   output logic [2:0]             pipe_shift_amt_o,
   output logic [31:0]            pipe_ext_data_o,
   output logic                   pipe_is_upper_o,
   output logic                   pipe_is_lower_o,
   input  logic                   pipe_en_out_i,
   input  logic [7:0]             pipe_data_out_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [7:0]             out_data_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int KEY_W = 3 * KEY_SLOTS;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   key_q;
   logic [2:0]         key_len_q;
   logic [2:0]         key_idx_q;
   logic               mode_q;
   logic [1:0]         inflight_q, inflight_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [7:0]         fifo_mem [FIFO_DEPTH];

   logic               pipe_en_q, pipe_shift_en_q, pipe_mode_q;
   logic [2:0]         pipe_shift_amt_q;
   logic [31:0]        pipe_ext_data_q;
   logic               pipe_is_upper_q, pipe_is_lower_q;

   logic               in_upper, in_lower, in_alpha;
   logic [4:0]         alpha_off;
   logic [31:0]        ext_data;
   logic [2:0]         slot_amt, shift_amt;
   logic [2:0]         key_slot [KEY_SLOTS];
   logic               accept, push, pop;
   logic [31:0]        occupancy;

   // ---------------- control FSM ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cfg_load_i) state_d = LOAD;
         LOAD:    state_d = RUN;
         RUN:     if (cfg_load_i) state_d = DRAIN;
         DRAIN:   if (inflight_q == 2'd0) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- handshakes and credits ----------------
   assign pop        = out_valid_o && out_ready_i;
   // A return with nothing outstanding is a leftover from before a reset and is dropped.
   assign push       = pipe_en_out_i && (state_q != IDLE) && (inflight_q != 2'd0);
   assign occupancy  = 32'(count_q) + 32'(inflight_q);
   assign in_ready_o = (state_q == RUN) && ((occupancy < 32'(FIFO_DEPTH)) || pop);
   assign accept     = in_valid_i && in_ready_o;
   assign cfg_busy_o = (state_q != RUN);

   // ---------------- classification and key select ----------------
   assign in_upper  = (in_data_i >= 8'd65) && (in_data_i <= 8'd90);
   assign in_lower  = (in_data_i >= 8'd97) && (in_data_i <= 8'd122);
   assign in_alpha  = in_upper || in_lower;
   assign alpha_off = 5'(in_upper ? (in_data_i - 8'd65) : (in_data_i - 8'd97));
   assign ext_data  = in_alpha ? (32'd1 << (alpha_off + 5'd6)) : {24'b0, in_data_i};

   for (genvar gi = 0; gi < KEY_SLOTS; gi++) begin : g_slot
      assign key_slot[gi] = key_q[3*gi +: 3];
   end

   always_comb begin
      slot_amt = 3'd0;
      for (int k = 0; k < KEY_SLOTS; k++) begin
         if (key_idx_q == 3'(k)) slot_amt = key_slot[k];
      end
   end

   // The stage cannot shift by 7, so that key value saturates at 6.
   assign shift_amt = (slot_amt == 3'd7) ? 3'd6 : slot_amt;

   // ---------------- occupancy counters ----------------
   always_comb begin
      inflight_d = inflight_q;
      if (accept && !push)      inflight_d = inflight_q + 2'd1;
      else if (!accept && push) inflight_d = inflight_q - 2'd1;
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         key_q            <= '0;
         key_len_q        <= 3'd0;
         key_idx_q        <= 3'd0;
         mode_q           <= 1'b0;
         inflight_q       <= 2'd0;
         count_q          <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         pipe_en_q        <= 1'b0;
         pipe_shift_en_q  <= 1'b0;
         pipe_mode_q      <= 1'b0;
         pipe_shift_amt_q <= 3'd0;
         pipe_ext_data_q  <= 32'd0;
         pipe_is_upper_q  <= 1'b0;
         pipe_is_lower_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;

         if (state_q == LOAD) begin
            key_q     <= cfg_key_i;
            key_len_q <= cfg_key_len_i;
            mode_q    <= cfg_mode_i;
            key_idx_q <= 3'd0;
         end else if (accept && in_alpha) begin
            key_idx_q <= (key_idx_q == key_len_q) ? 3'd0 : key_idx_q + 3'd1;
         end

         // Stage controls live for exactly the one cycle after acceptance.
         pipe_en_q        <= accept;
         pipe_shift_en_q  <= accept && in_alpha;
         pipe_mode_q      <= accept && mode_q;
         pipe_shift_amt_q <= (accept && in_alpha) ? shift_amt : 3'd0;
         pipe_ext_data_q  <= accept ? ext_data : 32'd0;
         pipe_is_upper_q  <= accept && in_upper;
         pipe_is_lower_q  <= accept && in_lower;

         if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= pipe_data_out_i;
   end

   // ---------------- outputs ----------------
   assign out_valid_o      = (count_q != '0);
   assign out_data_o       = out_valid_o ? fifo_mem[rd_ptr_q] : 8'd0;
   assign pipe_en_o        = pipe_en_q;
   assign pipe_shift_en_o  = pipe_shift_en_q;
   assign pipe_mode_o      = pipe_mode_q;
   assign pipe_shift_amt_o = pipe_shift_amt_q;
   assign pipe_ext_data_o  = pipe_ext_data_q;
   assign pipe_is_upper_o  = pipe_is_upper_q;
   assign pipe_is_lower_o  = pipe_is_lower_q;

endmodule

// File: tb/tb_decrypt_pipe_seq.sv
// Directed bench for decrypt_pipe_seq with a two-cycle shift-stage model that
// decrypts alphabetic bytes by rotating them back within their alphabet.
module tb_decrypt_pipe_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_load_i;
   logic [23:0] cfg_key_i;
   logic [2:0]  cfg_key_len_i;
   logic        cfg_mode_i;
   logic        cfg_busy_o;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [7:0]  in_data_i;
   logic        pipe_en_o, pipe_shift_en_o, pipe_mode_o;
   logic [2:0]  pipe_shift_amt_o;
   logic [31:0] pipe_ext_data_o;
   logic        pipe_is_upper_o, pipe_is_lower_o;
   logic        pipe_en_out_i;
   logic [7:0]  pipe_data_out_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [7:0]  out_data_o;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [2:0]  amt;
      logic        sh;
      logic [31:0] ext;
      logic        up;
      logic        lo;
   } rec_t;

   logic [7:0] out_q[$];
   rec_t       pipe_q[$];

   always #5 clk = ~clk;

   decrypt_pipe_seq #(.FIFO_DEPTH(4), .KEY_SLOTS(8)) dut (
      .clk(clk), .rst(rst),
      .cfg_load_i(cfg_load_i), .cfg_key_i(cfg_key_i), .cfg_key_len_i(cfg_key_len_i),
      .cfg_mode_i(cfg_mode_i), .cfg_busy_o(cfg_busy_o),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .pipe_en_o(pipe_en_o), .pipe_shift_en_o(pipe_shift_en_o), .pipe_mode_o(pipe_mode_o),
      .pipe_shift_amt_o(pipe_shift_amt_o), .pipe_ext_data_o(pipe_ext_data_o),
      .pipe_is_upper_o(pipe_is_upper_o), .pipe_is_lower_o(pipe_is_lower_o),
      .pipe_en_out_i(pipe_en_out_i), .pipe_data_out_i(pipe_data_out_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
   );

   // Shift-stage model: rotate letters back by the amount when decrypting.
   function automatic logic [7:0] stage_fn(input logic [31:0] ext, input logic [2:0] amt,
                                           input logic sh, input logic mode,
                                           input logic up, input logic lo);
      int i;
      int base;
      if (!(up || lo)) return ext[7:0];
      i = 0;
      for (int k = 6; k < 32; k++) if (ext[k]) i = k - 6;
      base = up ? 65 : 97;
      if (sh && mode) i = (i - int'(amt) + 26) % 26;
      return 8'(base + i);
   endfunction

   logic       s1_v = 1'b0, s2_v = 1'b0;
   logic [7:0] s1_d = 8'd0, s2_d = 8'd0;
   always @(posedge clk) begin
      s1_v <= pipe_en_o;
      s1_d <= stage_fn(pipe_ext_data_o, pipe_shift_amt_o, pipe_shift_en_o, pipe_mode_o,
                       pipe_is_upper_o, pipe_is_lower_o);
      s2_v <= s1_v;
      s2_d <= s1_d;
   end
   assign pipe_en_out_i   = s2_v;
   assign pipe_data_out_i = s2_d;

   always @(negedge clk) begin
      if (out_valid_o && out_ready_i) out_q.push_back(out_data_o);
      if (pipe_en_o) pipe_q.push_back('{pipe_shift_amt_o, pipe_shift_en_o, pipe_ext_data_o,
                                         pipe_is_upper_o, pipe_is_lower_o});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready_cfg();
      int n = 0;
      while (cfg_busy_o && n < 20) begin
         step();
         n++;
      end
      check("load_done", {31'd0, cfg_busy_o}, 32'd0);
   endtask

   task automatic load(input logic [23:0] key, input logic [2:0] len, input logic mode);
      cfg_key_i     = key;
      cfg_key_len_i = len;
      cfg_mode_i    = mode;
      cfg_load_i    = 1'b1;
      step();
      cfg_load_i    = 1'b0;
      wait_ready_cfg();
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_valid_i = 1'b1;
      in_data_i  = b;
      @(negedge clk);
      while (!in_ready_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      step();
      in_valid_i = 1'b0;
      check("send_accepted", {31'd0, n < 40}, 32'd1);
   endtask

   task automatic wait_outs(input int cnt);
      int c = 0;
      while (out_q.size() < cnt && c < 40) begin
         step();
         c++;
      end
      repeat (3) step();
      check("out_count", out_q.size(), cnt);
   endtask

   initial begin
      int acc;
      rst = 1'b0; cfg_load_i = 1'b0; cfg_key_i = 24'd0; cfg_key_len_i = 3'd0;
      cfg_mode_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'd0; out_ready_i = 1'b1;

      // Reset values
      repeat (3) step();
      check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_out_data", {24'd0, out_data_o}, 32'd0);
      check("rst_busy", {31'd0, cfg_busy_o}, 32'd1);
      check("rst_pipe_en", {31'd0, pipe_en_o}, 32'd0);
      rst = 1'b1;
      step();
      check("idle_busy", {31'd0, cfg_busy_o}, 32'd1);

      // Key {1,2,3}, decrypt "abcd" then "-e"
      load(24'o321, 3'd2, 1'b1);
      out_q.delete(); pipe_q.delete();
      send("a"); send("b"); send("c"); send("d");
      wait_outs(4);
      check("abcd_amt0", {29'd0, pipe_q[0].amt}, 32'd1);
      check("abcd_amt1", {29'd0, pipe_q[1].amt}, 32'd2);
      check("abcd_amt2", {29'd0, pipe_q[2].amt}, 32'd3);
      check("abcd_amt3", {29'd0, pipe_q[3].amt}, 32'd1);
      check("a_ext", pipe_q[0].ext, 32'h40);
      check("a_lower", {31'd0, pipe_q[0].lo}, 32'd1);
      check("abcd_out0", {24'd0, out_q[0]}, 32'h7A);
      check("abcd_out1", {24'd0, out_q[1]}, 32'h7A);
      check("abcd_out2", {24'd0, out_q[2]}, 32'h7A);
      check("abcd_out3", {24'd0, out_q[3]}, 32'h63);
      out_q.delete(); pipe_q.delete();
      send("-"); send("e");
      wait_outs(2);
      check("dash_amt", {29'd0, pipe_q[0].amt}, 32'd0);
      check("e_keeps_idx_amt", {29'd0, pipe_q[1].amt}, 32'd2);
      check("e_out", {24'd0, out_q[1]}, 32'h63);

      // Key {5}, "A-B"
      load(24'o5, 3'd0, 1'b1);
      out_q.delete(); pipe_q.delete();
      send("A"); send("-"); send("B");
      wait_outs(3);
      check("A_upper", {31'd0, pipe_q[0].up}, 32'd1);
      check("A_ext", pipe_q[0].ext, 32'h40);
      check("dash_shift_en", {31'd0, pipe_q[1].sh}, 32'd0);
      check("dash_ext", pipe_q[1].ext, 32'h2D);
      check("B_amt", {29'd0, pipe_q[2].amt}, 32'd5);
      check("AB_out0", {24'd0, out_q[0]}, 32'h56);
      check("AB_out1", {24'd0, out_q[1]}, 32'h2D);
      check("AB_out2", {24'd0, out_q[2]}, 32'h57);

      // Backpressure: credits stop acceptance at 4
      out_q.delete(); pipe_q.delete();
      out_ready_i = 1'b0;
      acc = 0;
      in_valid_i = 1'b1;
      in_data_i  = 8'h31;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (in_ready_o) acc++;
         step();
         in_data_i = 8'(49 + acc);
      end
      in_valid_i = 1'b0;
      check("bp_accepted", acc, 4);
      @(negedge clk);
      check("bp_in_ready_low", {31'd0, in_ready_o}, 32'd0);
      step();
      out_ready_i = 1'b1;
      @(negedge clk);
      check("bp_ready_in_pop_cycle", {31'd0, in_ready_o}, 32'd1);
      step();
      wait_outs(4);
      check("bp_out0", {24'd0, out_q[0]}, 32'h31);
      check("bp_out1", {24'd0, out_q[1]}, 32'h32);
      check("bp_out2", {24'd0, out_q[2]}, 32'h33);
      check("bp_out3", {24'd0, out_q[3]}, 32'h34);

      // Slot value 7 saturates to 6
      load(24'o7, 3'd0, 1'b1);
      out_q.delete(); pipe_q.delete();
      send("a");
      wait_outs(1);
      check("clamp_amt", {29'd0, pipe_q[0].amt}, 32'd6);
      check("clamp_out", {24'd0, out_q[0]}, 32'h75);

      // Reload with two bytes in flight
      out_q.delete(); pipe_q.delete();
      cfg_key_i = 24'o1;
      send("b"); send("c");
      cfg_load_i = 1'b1;
      step();
      cfg_load_i = 1'b0;
      @(negedge clk);
      check("drain_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("drain_busy", {31'd0, cfg_busy_o}, 32'd1);
      wait_ready_cfg();
      send("d");
      wait_outs(3);
      check("reload_amt_old", {29'd0, pipe_q[1].amt}, 32'd6);
      check("reload_amt_new", {29'd0, pipe_q[2].amt}, 32'd1);
      check("reload_out0", {24'd0, out_q[0]}, 32'h76);
      check("reload_out1", {24'd0, out_q[1]}, 32'h77);
      check("reload_out2", {24'd0, out_q[2]}, 32'h63);

      // Reset with three buffered bytes and one in flight
      out_ready_i = 1'b0;
      send("x"); send("y"); send("z");
      repeat (6) step();
      check("buffered_valid", {31'd0, out_valid_o}, 32'd1);
      send("!");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("midrst_busy", {31'd0, cfg_busy_o}, 32'd1);
      check("midrst_out_data", {24'd0, out_data_o}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("midrst_pipe_en", {31'd0, pipe_en_o}, 32'd0);
      step();
      rst = 1'b1;
      repeat (4) step();
      out_ready_i = 1'b1;
      out_q.delete(); pipe_q.delete();
      repeat (4) step();
      check("no_stale_idle", out_q.size(), 0);
      load(24'o1, 3'd0, 1'b1);
      check("empty_after_reload", {31'd0, out_valid_o}, 32'd0);
      send("b");
      wait_outs(1);
      check("post_reset_out", {24'd0, out_q[0]}, 32'h61);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
